// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: states, opcode classes,
// opcode constants, ALU operation codes and fault codes.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsR      = 3'd0,
    ClsIalu   = 3'd1,
    ClsLoad   = 3'd2,
    ClsStore  = 3'd3,
    ClsBranch = 3'd4
  } op_class_e;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIalu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluSub    = 2'b01;
  localparam logic [1:0] AluRFunct = 2'b10;
  localparam logic [1:0] AluIFunct = 2'b11;

  localparam logic [1:0] FaultNone      = 2'b00;
  localparam logic [1:0] FaultIllegal   = 2'b01;
  localparam logic [1:0] FaultImTimeout = 2'b10;
  localparam logic [1:0] FaultDmTimeout = 2'b11;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: maps instruction[6:0] to an instruction class
// and flags anything outside the supported set as illegal.
module control_sequencer_opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] op_class_o,
  output logic       illegal_o
);

  // Classify the opcode; illegal opcodes report class R but are never executed.
  always_comb begin
    op_class_o = ClsR;
    illegal_o  = 1'b0;
    unique case (opcode_i)
      OpcR:      op_class_o = ClsR;
      OpcIalu:   op_class_o = ClsIalu;
      OpcLoad:   op_class_o = ClsLoad;
      OpcStore:  op_class_o = ClsStore;
      OpcBranch: op_class_o = ClsBranch;
      default:   illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM with
// request/acknowledge memory handshakes, wait timeouts, sticky fault reporting and
// a retired-instruction counter.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_OPCode,
  input  logic                 i_Zero,
  output logic                 o_IMReq,
  input  logic                 i_IMAck,
  output logic                 o_DMReq,
  input  logic                 i_DMAck,
  output logic                 o_IRWrite,
  output logic                 o_PCWrite,
  output logic                 o_PCSel,
  output logic                 o_Branch,
  output logic                 o_MemRead,
  output logic                 o_MemWrite,
  output logic                 o_MemToReg,
  output logic                 o_ALUSrc,
  output logic                 o_RegWrite,
  output logic [1:0]           o_ALUOp,
  output logic [2:0]           o_State,
  output logic                 o_Fault,
  output logic [1:0]           o_FaultCode,
  output logic [CNT_WIDTH-1:0] o_Retired
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  // Count value seen during the last permitted unacknowledged request cycle.
  localparam logic [WaitW-1:0] TimeoutLast = WaitW'(MEM_TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [6:0]             opcode_q, opcode_d;
  logic                   fault_q, fault_d;
  logic [1:0]             code_q, code_d;
  logic [CNT_WIDTH-1:0]   retired_q;

  logic [2:0]             dec_class_raw;
  op_class_e              dec_class;
  logic                   dec_illegal;
  logic                   wait_expired;

  control_sequencer_opcode_decoder u_opcode_decoder (
    .opcode_i   (opcode_q),
    .op_class_o (dec_class_raw),
    .illegal_o  (dec_illegal)
  );

  assign dec_class    = op_class_e'(dec_class_raw);
  assign wait_expired = (wait_q == TimeoutLast);

  assign o_State     = state_q;
  assign o_Fault     = fault_q;
  assign o_FaultCode = code_q;
  assign o_Retired   = retired_q;

  // Next-state, wait counter and control outputs; any state change clears the wait counter.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    opcode_d   = opcode_q;
    fault_d    = fault_q;
    code_d     = code_q;
    o_IMReq    = 1'b0;
    o_DMReq    = 1'b0;
    o_IRWrite  = 1'b0;
    o_PCWrite  = 1'b0;
    o_PCSel    = 1'b0;
    o_Branch   = 1'b0;
    o_MemRead  = 1'b0;
    o_MemWrite = 1'b0;
    o_MemToReg = 1'b0;
    o_ALUSrc   = 1'b0;
    o_RegWrite = 1'b0;
    o_ALUOp    = AluAdd;

    case (state_q)
      StFetch: begin
        o_IMReq = 1'b1;
        if (i_IMAck) begin
          o_IRWrite = 1'b1;
          opcode_d  = i_OPCode;
          state_d   = StDecode;
        end else if (wait_expired) begin
          state_d = StHalt;
          fault_d = 1'b1;
          code_d  = FaultImTimeout;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StDecode: begin
        if (dec_illegal) begin
          state_d = StHalt;
          fault_d = 1'b1;
          code_d  = FaultIllegal;
        end else begin
          state_d = StExecute;
        end
      end

      StExecute: begin
        case (dec_class)
          ClsR: begin
            o_ALUOp = AluRFunct;
            state_d = StWriteback;
          end
          ClsIalu: begin
            o_ALUOp  = AluIFunct;
            o_ALUSrc = 1'b1;
            state_d  = StWriteback;
          end
          ClsLoad, ClsStore: begin
            o_ALUOp  = AluAdd;
            o_ALUSrc = 1'b1;
            state_d  = StMemory;
          end
          ClsBranch: begin
            o_ALUOp   = AluSub;
            o_Branch  = 1'b1;
            o_PCWrite = 1'b1;
            o_PCSel   = i_Zero;
            state_d   = StFetch;
          end
          default: begin
            state_d = StHalt;
            fault_d = 1'b1;
            code_d  = FaultNone;
          end
        endcase
      end

      StMemory: begin
        o_DMReq    = 1'b1;
        o_ALUOp    = AluAdd;
        o_ALUSrc   = 1'b1;
        o_MemRead  = (dec_class == ClsLoad);
        o_MemWrite = (dec_class == ClsStore);
        if (i_DMAck) begin
          if (dec_class == ClsStore) begin
            o_PCWrite = 1'b1;
            state_d   = StFetch;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_expired) begin
          state_d = StHalt;
          fault_d = 1'b1;
          code_d  = FaultDmTimeout;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end

      StWriteback: begin
        o_RegWrite = 1'b1;
        o_MemToReg = (dec_class == ClsLoad);
        o_PCWrite  = 1'b1;
        state_d    = StFetch;
      end

      StHalt: begin
        state_d = StHalt;
      end

      // Unused encodings park in HALT without a fault cause.
      default: begin
        state_d = StHalt;
        fault_d = 1'b1;
        code_d  = FaultNone;
      end
    endcase

    // Reset suppresses every control strobe, including ones a pending ack would cause.
    if (i_rst) begin
      o_IMReq    = 1'b0;
      o_DMReq    = 1'b0;
      o_IRWrite  = 1'b0;
      o_PCWrite  = 1'b0;
      o_PCSel    = 1'b0;
      o_Branch   = 1'b0;
      o_MemRead  = 1'b0;
      o_MemWrite = 1'b0;
      o_MemToReg = 1'b0;
      o_ALUSrc   = 1'b0;
      o_RegWrite = 1'b0;
      o_ALUOp    = AluAdd;
    end
  end

  // State, captured opcode, fault and retired-count registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      opcode_q  <= '0;
      fault_q   <= 1'b0;
      code_q    <= FaultNone;
      retired_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      opcode_q <= opcode_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
      if (o_PCWrite) begin
        retired_q <= retired_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: builds each instruction's expected
// cycle trace from its class and memory wait times, then replays it cycle by cycle.
module tb_control_sequencer;

  localparam int MemTo = 16;
  // Narrow counter so the all-ones to zero wrap is reachable in a short run.
  localparam int CntW  = 4;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [6:0]      i_OPCode = '0;
  logic            i_Zero = 1'b0;
  logic            i_IMAck = 1'b0;
  logic            i_DMAck = 1'b0;
  logic            o_IMReq, o_DMReq, o_IRWrite, o_PCWrite, o_PCSel, o_Branch;
  logic            o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc, o_RegWrite, o_Fault;
  logic [1:0]      o_ALUOp, o_FaultCode;
  logic [2:0]      o_State;
  logic [CntW-1:0] o_Retired;

  control_sequencer #(
    .MEM_TIMEOUT (MemTo),
    .CNT_WIDTH   (CntW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_OPCode    (i_OPCode),
    .i_Zero      (i_Zero),
    .o_IMReq     (o_IMReq),
    .i_IMAck     (i_IMAck),
    .o_DMReq     (o_DMReq),
    .i_DMAck     (i_DMAck),
    .o_IRWrite   (o_IRWrite),
    .o_PCWrite   (o_PCWrite),
    .o_PCSel     (o_PCSel),
    .o_Branch    (o_Branch),
    .o_MemRead   (o_MemRead),
    .o_MemWrite  (o_MemWrite),
    .o_MemToReg  (o_MemToReg),
    .o_ALUSrc    (o_ALUSrc),
    .o_RegWrite  (o_RegWrite),
    .o_ALUOp     (o_ALUOp),
    .o_State     (o_State),
    .o_Fault     (o_Fault),
    .o_FaultCode (o_FaultCode),
    .o_Retired   (o_Retired)
  );

  always #5 i_clk = ~i_clk;

  // Observed vector: {state, fault, code, imreq, dmreq, irwrite, pcwrite, pcsel,
  //                   branch, memread, memwrite, memtoreg, alusrc, regwrite, aluop}
  logic [18:0] obs;
  assign obs = {o_State, o_Fault, o_FaultCode, o_IMReq, o_DMReq, o_IRWrite, o_PCWrite,
                o_PCSel, o_Branch, o_MemRead, o_MemWrite, o_MemToReg, o_ALUSrc,
                o_RegWrite, o_ALUOp};

  int checks = 0;
  int errors = 0;
  int model_ret = 0;

  logic [18:0]     exp_q[$];
  logic            ima_q[$];
  logic            dma_q[$];
  logic [6:0]      opc_q[$];
  logic [CntW-1:0] ret_q[$];

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 R, 1 IALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 illegal
  function automatic int classify(input logic [6:0] op);
    if (op == 7'b0110011) return 0;
    if (op == 7'b0010011) return 1;
    if (op == 7'b0000011) return 2;
    if (op == 7'b0100011) return 3;
    if (op == 7'b1100011) return 4;
    return 5;
  endfunction

  function automatic logic [18:0] ent(input logic [2:0] st, input logic f,
      input logic [1:0] code, input logic imr, input logic dmr, input logic irw,
      input logic pcw, input logic pcs, input logic br, input logic mr, input logic mw,
      input logic m2r, input logic src, input logic rgw, input logic [1:0] alu);
    return {st, f, code, imr, dmr, irw, pcw, pcs, br, mr, mw, m2r, src, rgw, alu};
  endfunction

  task automatic push(input logic [18:0] e, input logic ima, input logic dma,
                      input logic [6:0] opc);
    exp_q.push_back(e);
    ima_q.push_back(ima);
    dma_q.push_back(dma);
    opc_q.push_back(opc);
    ret_q.push_back(CntW'(model_ret));
    if (e[9]) model_ret = (model_ret + 1) % (1 << CntW);
  endtask

  task automatic add_halt(input logic [1:0] code);
    for (int i = 0; i < 3; i++)
      push(ent(3'd5, 1'b1, code, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rb(), rb(),
           7'($urandom));
  endtask

  // Expected trace for one instruction; stray acks are thrown in where no request is up.
  task automatic build_trace(input logic [6:0] op, input int im_wait, input int dm_wait,
                             input logic z, output bit halted);
    int cls;
    int n;
    logic ack, br, ld, st, src;
    logic [1:0] alu;
    cls = classify(op);
    halted = 1'b0;
    n = (im_wait >= MemTo) ? MemTo : im_wait + 1;
    for (int i = 0; i < n; i++) begin
      ack = (i == im_wait);
      push(ent(3'd0, 0, 2'b00, 1, 0, ack, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), ack, rb(),
           ack ? op : 7'($urandom));
    end
    if (im_wait >= MemTo) begin
      add_halt(2'b10);
      halted = 1'b1;
      return;
    end
    push(ent(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), rb(), rb(),
         7'($urandom));
    if (cls == 5) begin
      add_halt(2'b01);
      halted = 1'b1;
      return;
    end
    br  = (cls == 4);
    ld  = (cls == 2);
    st  = (cls == 3);
    src = (cls == 1) || ld || st;
    alu = (cls == 0) ? 2'b10 : (cls == 1) ? 2'b11 : br ? 2'b01 : 2'b00;
    push(ent(3'd2, 0, 2'b00, 0, 0, 0, br, br & z, br, 0, 0, 0, src, 0, alu), rb(), rb(),
         7'($urandom));
    if (br) return;
    if (ld || st) begin
      n = (dm_wait >= MemTo) ? MemTo : dm_wait + 1;
      for (int i = 0; i < n; i++) begin
        ack = (i == dm_wait);
        push(ent(3'd3, 0, 2'b00, 0, 1, 0, ack & st, 0, 0, ld, st, 0, 1, 0, 2'b00), rb(), ack,
             7'($urandom));
      end
      if (dm_wait >= MemTo) begin
        add_halt(2'b11);
        halted = 1'b1;
        return;
      end
      if (st) return;
    end
    push(ent(3'd4, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, ld, 0, 1, 2'b00), rb(), rb(),
         7'($urandom));
  endtask

  // Replays the queued trace: inputs at posedge+1, outputs sampled at the negedge.
  task automatic run_trace(input string name);
    logic [18:0] e;
    logic [CntW-1:0] r;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e        = exp_q.pop_front();
      i_IMAck  = ima_q.pop_front();
      i_DMAck  = dma_q.pop_front();
      i_OPCode = opc_q.pop_front();
      r        = ret_q.pop_front();
      #4;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: outputs got %b want %b", name, cyc, obs, e);
      end
      checks++;
      if (o_Retired !== r) begin
        errors++;
        $display("FAIL %s cycle %0d: retired got %0d want %0d", name, cyc, o_Retired, r);
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_IMAck = 1'b0;
    i_DMAck = 1'b0;
  endtask

  task automatic do_reset(input string name);
    i_rst   = 1'b1;
    i_IMAck = rb();
    i_DMAck = rb();
    @(posedge i_clk); #1;
    #4;
    checks++;
    if (obs !== 19'd0) begin
      errors++;
      $display("FAIL %s reset outputs got %b want 0", name, obs);
    end
    checks++;
    if (o_Retired !== '0) begin
      errors++;
      $display("FAIL %s reset retired got %0d want 0", name, o_Retired);
    end
    @(posedge i_clk); #1;
    i_rst   = 1'b0;
    i_IMAck = 1'b0;
    i_DMAck = 1'b0;
    model_ret = 0;
  endtask

  task automatic do_instr(input string name, input logic [6:0] op, input int imw,
                          input int dmw, input logic z);
    bit halted;
    i_Zero = z;
    build_trace(op, imw, dmw, z, halted);
    run_trace(name);
    if (halted) do_reset(name);
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_rtype();
    do_instr("rtype", 7'b0110011, 0, 0, 1'b0);
    do_instr("ialu", 7'b0010011, 0, 0, 1'b1);
  endtask

  task automatic test_load_wait();
    do_instr("load_dm3", 7'b0000011, 0, 3, 1'b0);
    do_instr("store_dm0", 7'b0100011, 0, 0, 1'b0);
  endtask

  task automatic test_branch();
    do_instr("branch_z1", 7'b1100011, 0, 0, 1'b1);
    do_instr("branch_z0", 7'b1100011, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    do_instr("illegal", 7'b1111111, 0, 0, 1'b0);
  endtask

  task automatic test_timeouts();
    do_instr("im_ack16", 7'b0110011, MemTo - 1, 0, 1'b0);
    do_instr("im_timeout", 7'b0110011, MemTo, 0, 1'b0);
    do_instr("dm_ack16", 7'b0000011, 0, MemTo - 1, 1'b0);
    do_instr("dm_timeout", 7'b0100011, 1, MemTo, 1'b0);
  endtask

  task automatic test_reset_mid_store();
    do_instr("pre_store", 7'b0110011, 0, 0, 1'b0);
    i_OPCode = 7'b0100011;
    i_IMAck  = 1'b1;
    @(posedge i_clk); #1;
    i_IMAck = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #4;
    checks++;
    if (o_State !== 3'd3 || o_MemWrite !== 1'b1 || o_DMReq !== 1'b1) begin
      errors++;
      $display("FAIL mid_store pre: state %0d memwrite %b dmreq %b want 3 1 1",
               o_State, o_MemWrite, o_DMReq);
    end
    i_rst   = 1'b1;
    i_DMAck = 1'b1;
    #1;
    checks++;
    if (o_MemWrite !== 1'b0 || o_PCWrite !== 1'b0 || o_RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL mid_store rst: memwrite %b pcwrite %b regwrite %b want 0 0 0",
               o_MemWrite, o_PCWrite, o_RegWrite);
    end
    @(posedge i_clk); #1;
    i_rst   = 1'b0;
    i_DMAck = 1'b0;
    #4;
    checks++;
    if (o_State !== 3'd0 || o_IMReq !== 1'b1 || o_MemWrite !== 1'b0 || o_Retired !== '0) begin
      errors++;
      $display("FAIL mid_store post: state %0d imreq %b memwrite %b retired %0d want 0 1 0 0",
               o_State, o_IMReq, o_MemWrite, o_Retired);
    end
    do_reset("mid_store_cleanup");
  endtask

  task automatic test_retire_wrap();
    do_reset("wrap_reset");
    for (int i = 0; i < (1 << CntW) - 1; i++)
      do_instr("wrap_fill", 7'b1100011, 0, 0, rb());
    checks++;
    if (o_Retired !== {CntW{1'b1}}) begin
      errors++;
      $display("FAIL wrap_allones got %0d want %0d", o_Retired, (1 << CntW) - 1);
    end
    do_instr("wrap_step", 7'b0110011, 0, 0, 1'b0);
    checks++;
    if (o_Retired !== '0) begin
      errors++;
      $display("FAIL wrap_zero got %0d want 0", o_Retired);
    end
  endtask

  function automatic int pick_wait();
    int p;
    p = $urandom_range(0, 24);
    if (p == 0) return MemTo + $urandom_range(0, 2);
    if (p == 1) return MemTo - 1;
    return $urandom_range(0, 3);
  endfunction

  task automatic test_back_to_back();
    logic [6:0] op;
    int k;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1:    op = 7'b0110011;
        2, 3:    op = 7'b0010011;
        4, 5:    op = 7'b0000011;
        6:       op = 7'b0100011;
        7, 8:    op = 7'b1100011;
        default: op = 7'($urandom);
      endcase
      do_instr("random", op, pick_wait(), pick_wait(), rb());
    end
  endtask

  initial begin
    @(posedge i_clk); #1;
    test_reset();
    test_rtype();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeouts();
    test_reset_mid_store();
    test_retire_wrap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
